cpu_onchip_mem_arbiter: RTL and testbench
=========================================

// Module: cpu_onchip_mem_arbiter
// PURPOSE
//  Shares the single-port 1024x32 on-chip RAM between two Avalon-MM masters (m0, m1).
//  Round-robin arbitration at burst granularity; bursts expand to sequential word
//  accesses. Sits between the two masters and the RAM slave port.
//  RAM read latency is fixed at 1 clk (registered address, unregistered q).
// PARAMETERS
//  ADDR_W    10  word-address width (RAM depth = 2**ADDR_W)
//  BC_W       4  burstcount width; max burst = 2**(BC_W-1) beats
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       asynchronous, active-low reset
//  mN_address       in   ADDR_W  word address, N=0,1
//  mN_read          in   1       read command
//  mN_write         in   1       write command / write beat valid
//  mN_byteenable    in   4       byte lanes for write beat
//  mN_writedata     in   32      write beat data
//  mN_burstcount    in   BC_W    beats in burst; 0 treated as 1
//  mN_waitrequest   out  1       1 = command/beat not accepted this cycle
//  mN_readdata      out  32      read data, qualified by mN_readdatavalid
//  mN_readdatavalid out  1       one pulse per returned read beat
//  mem_address      out  ADDR_W  RAM address
//  mem_chipselect   out  1       RAM access this cycle
//  mem_write        out  1       RAM write this cycle
//  mem_byteenable   out  4       RAM byte enables
//  mem_writedata    out  32      RAM write data
//  mem_readdata     in   32      RAM q (valid 1 clk after read issue)
//  mem_clken        out  1       RAM clock enable; constant 1 out of reset
// BEHAVIOUR
//  Reset: state IDLE, last_grant=1 (m0 wins first tie), beat counter 0, rd pipe empty.
//   Outputs: mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0, mem_chipselect=0,
//   mem_write=0, mem_clken=0. Reset mid-burst aborts it; in-flight read beat dropped.
//  Request: mN_read|mN_write. Both set on one master -> treated as write.
//  States IDLE, RD_BURST, WR_BURST.
//  IDLE: one requester -> granted; both -> master != last_grant granted.
//   Grant is combinational: winner sees waitrequest=0 same cycle; its first RAM
//   access issues that cycle at mN_address. last_grant <= winner on accept.
//   burstcount<=1 -> stay IDLE (back-to-back single beats, no bubble).
//   Else latch base addr, remaining=N-1, go RD_BURST or WR_BURST.
//  RD_BURST: one read per cycle at base+k (k=1..N-1), owner waitrequest=1 for any
//   new command. Issue of last beat -> IDLE; next command acceptable next cycle.
//  WR_BURST: each cycle owner asserts mN_write -> waitrequest=0, beat written at
//   base+k with that cycle's byteenable/writedata, k++. mN_write=0 -> stall, no RAM
//   access, remain. Last beat accepted -> IDLE.
//  Non-owner requesting: waitrequest=1 until a later IDLE grant. Idle master: 1.
//  Address increment wraps mod 2**ADDR_W (1023 -> 0).
//  Read return: 1-entry pipe records owner of each issued read; next cycle that
//   owner gets readdatavalid=1, readdata=mem_readdata. Other master's readdata
//   holds last value. N-beat read -> N consecutive valids, starting 1 clk after accept.
//  mem_chipselect=1 only on issuing cycles; mem_write=1 only on write beats.
//  Fairness: with both continuously requesting, grants alternate per burst.
// TESTING
//  1. m0 single write 0x3FF,be=F,data=0xDEADBEEF; then read 0x3FF -> valid 1 clk after accept, data 0xDEADBEEF.
//  2. m0,m1 read same cycle after reset -> m0 first, m1 next cycle; grants alternate over 8 tries.
//  3. m1 4-beat read from 0x3FE -> mem_address 3FE,3FF,000,001 on consecutive clks; 4 valids.
//  4. m0 4-beat write with write deasserted beat 2 for 3 clks -> 3 stall clks, 4 writes, m1 waits throughout.
//  5. m0 write be=4'b0010 data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
//  6. reset_n low mid 8-beat read -> all valids 0, waitrequest 1; after release m0 wins first.

Source files
------------

// File: rtl/cpu_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two
// Avalon-MM burst masters; bursts are expanded into sequential word accesses.
module cpu_onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int BC_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    input  logic [BC_W-1:0]   m0_burstcount,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    input  logic [BC_W-1:0]   m1_burstcount,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              clken;
    logic              rd_vld;
    logic              rd_own;
    logic [ADDR_W-1:0] addr_q;
    logic [BC_W-1:0]   remaining;
    logic [31:0]       hold0;
    logic [31:0]       hold1;

    logic              req0;
    logic              req1;
    logic              win;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic [BC_W-1:0]   win_bc;
    logic [BC_W-1:0]   win_bc_eff;
    logic              win_write;
    logic [3:0]        win_be;
    logic [31:0]       win_data;
    logic              own_write;
    logic [3:0]        own_be;
    logic [31:0]       own_data;
    logic              issue;
    logic              issue_wr;
    logic              issue_own;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On a tie the master that did not win last time is served.
    assign win   = (req0 && req1) ? ~last_grant : req1;
    assign grant = clken && (state == IDLE) && (req0 || req1);

    assign win_addr   = win ? m1_address    : m0_address;
    assign win_bc     = win ? m1_burstcount : m0_burstcount;
    assign win_write  = win ? m1_write      : m0_write;
    assign win_be     = win ? m1_byteenable : m0_byteenable;
    assign win_data   = win ? m1_writedata  : m0_writedata;
    assign win_bc_eff = (win_bc == '0) ? BC_W'(1) : win_bc;

    assign own_write = owner ? m1_write      : m0_write;
    assign own_be    = owner ? m1_byteenable : m0_byteenable;
    assign own_data  = owner ? m1_writedata  : m0_writedata;

    always_comb begin
        issue          = 1'b0;
        issue_wr       = 1'b0;
        issue_own      = owner;
        mem_address    = addr_q;
        mem_byteenable = 4'hF;
        mem_writedata  = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    issue          = 1'b1;
                    issue_wr       = win_write;
                    issue_own      = win;
                    mem_address    = win_addr;
                    m0_waitrequest = win;
                    m1_waitrequest = ~win;
                    if (win_write) begin
                        mem_byteenable = win_be;
                        mem_writedata  = win_data;
                    end
                end
            end
            RD_BURST: begin
                issue = 1'b1;
            end
            WR_BURST: begin
                if (own_write) begin
                    issue          = 1'b1;
                    issue_wr       = 1'b1;
                    mem_byteenable = own_be;
                    mem_writedata  = own_data;
                    m0_waitrequest = owner;
                    m1_waitrequest = ~owner;
                end
            end
            default: ;
        endcase
    end

    assign mem_chipselect = issue;
    assign mem_write      = issue & issue_wr;
    assign mem_clken      = clken;

    assign m0_readdatavalid = rd_vld & ~rd_own;
    assign m1_readdatavalid = rd_vld & rd_own;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : hold0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : hold1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            clken      <= 1'b0;
            rd_vld     <= 1'b0;
            rd_own     <= 1'b0;
            addr_q     <= '0;
            remaining  <= '0;
            hold0      <= '0;
            hold1      <= '0;
        end else begin
            clken  <= 1'b1;
            rd_vld <= issue & ~issue_wr;
            rd_own <= issue_own;
            if (rd_vld && !rd_own) hold0 <= mem_readdata;
            if (rd_vld && rd_own)  hold1 <= mem_readdata;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        last_grant <= win;
                        if (win_bc_eff != BC_W'(1)) begin
                            owner     <= win;
                            addr_q    <= win_addr + 1'b1;
                            remaining <= win_bc_eff - 1'b1;
                            state     <= win_write ? WR_BURST : RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    addr_q    <= addr_q + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == BC_W'(1)) state <= IDLE;
                end
                WR_BURST: begin
                    if (own_write) begin
                        addr_q    <= addr_q + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == BC_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_onchip_mem_arbiter.sv
// Scoreboard bench for cpu_onchip_mem_arbiter: a shadow memory predicts read
// data at command accept; a monitor pops and compares each returned beat.
`timescale 1ns/1ps
module tb_cpu_onchip_mem_arbiter;
    localparam int AW = 10;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] a_r [2];
    logic          rd_r [2];
    logic          wr_r [2];
    logic [3:0]    be_r [2];
    logic [31:0]   wd_r [2];
    logic [BW-1:0] bc_r [2];

    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata, mem_readdata;

    cpu_onchip_mem_arbiter #(.ADDR_W(AW), .BC_W(BW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(a_r[0]), .m0_read(rd_r[0]), .m0_write(wr_r[0]),
        .m0_byteenable(be_r[0]), .m0_writedata(wd_r[0]),
        .m0_burstcount(bc_r[0]), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(a_r[1]), .m1_read(rd_r[1]), .m1_write(wr_r[1]),
        .m1_byteenable(be_r[1]), .m1_writedata(wd_r[1]),
        .m1_burstcount(bc_r[1]), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] shadow [1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic int idx(logic [AW-1:0] a, int k);
        return (int'(a) + k) % 1024;
    endfunction

    function automatic logic waitreq(int m);
        return m != 0 ? m1_waitrequest : m0_waitrequest;
    endfunction

    // RAM slave: registered address, unregistered q.
    logic [31:0]   ram [1024];
    logic [AW-1:0] ram_a = '0;
    bit            ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write)
                ram[mem_address] <= merge(ram[mem_address], mem_writedata,
                                          mem_byteenable);
            ram_a <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_a];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int m, input logic [31:0] v);
        if (m != 0) q1.push_back(v);
        else q0.push_back(v);
    endtask

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (m0_readdatavalid) begin
                if (q0.size() == 0) chk("rd_unexpected_m0", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("rd_data_m0", m0_readdata, e);
                end
            end
            if (m1_readdatavalid) begin
                if (q1.size() == 0) chk("rd_unexpected_m1", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("rd_data_m1", m1_readdata, e);
                end
            end
        end
    end

    task automatic wait_accept(input int m, input bit now, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!(now && t == 0)) @(negedge clk);
            if (!waitreq(m)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        chk($sformatf("accept_m%0d", m), 32'(ok), 32'd1);
    endtask

    task automatic first_grant(output logic [1:0] w);
        w = 2'b11;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!m0_waitrequest || !m1_waitrequest) begin
                w = {m1_waitrequest, m0_waitrequest};
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic do_rd(input int m, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc);
        bit ok;
        int n = (bc == '0) ? 1 : int'(bc);
        a_r[m] = a; bc_r[m] = bc; rd_r[m] = 1'b1; wr_r[m] = 1'b0;
        wait_accept(m, 1'b0, ok);
        if (ok) for (int k = 0; k < n; k++) push(m, shadow[idx(a, k)]);
        @(posedge clk); #1;
        rd_r[m] = 1'b0;
    endtask

    task automatic do_wr(input int m, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc, input logic [31:0] d0,
                         input logic [3:0] be0, input int stall_at,
                         input int stall_len);
        bit ok;
        int s;
        int n = (bc == '0) ? 1 : int'(bc);
        logic [31:0] d = d0;
        logic [3:0] be = be0;
        a_r[m] = a; bc_r[m] = bc; rd_r[m] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                d = $urandom;
                be = 4'($urandom_range(0, 15));
                s = (stall_at < 0) ? int'($urandom_range(0, 2)) :
                    (k == stall_at ? stall_len : 0);
                repeat (s) begin
                    wr_r[m] = 1'b0;
                    @(posedge clk); #1;
                end
            end
            wd_r[m] = d; be_r[m] = be; wr_r[m] = 1'b1;
            wait_accept(m, 1'b0, ok);
            if (ok) shadow[idx(a, k)] = merge(shadow[idx(a, k)], d, be);
            @(posedge clk); #1;
        end
        wr_r[m] = 1'b0;
    endtask

    task automatic rand_ops(input int m);
        logic [AW-1:0] a;
        logic [BW-1:0] bc;
        repeat (40) begin
            a = AW'(1016 + $urandom_range(0, 15));
            bc = BW'($urandom_range(0, 8));
            if ($urandom_range(0, 1) != 0) do_rd(m, a, bc);
            else do_wr(m, a, bc, $urandom, 4'($urandom_range(0, 15)), -1, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0] w;
        logic [AW-1:0] ea;
        bit ok, m0_done;
        int writes, first, last, bad, cnt, exp_w;
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
        for (int m = 0; m < 2; m++) begin
            a_r[m] = '0; rd_r[m] = 0; wr_r[m] = 0;
            be_r[m] = 4'hF; wd_r[m] = '0; bc_r[m] = BW'(1);
        end
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wait_m0", 32'(m0_waitrequest), 32'd1);
        chk("rst_wait_m1", 32'(m1_waitrequest), 32'd1);
        chk("rst_valid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        chk("rst_rdata_m0", m0_readdata, 32'd0);
        chk("rst_cs_we", 32'({mem_chipselect, mem_write}), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("clken_run", 32'(mem_clken), 32'd1);

        do_wr(0, 10'h3FF, 4'd1, 32'hDEADBEEF, 4'hF, 0, 0);
        do_rd(0, 10'h3FF, 4'd1);
        @(negedge clk);
        chk("t1_valid_lat", 32'(m0_readdatavalid), 32'd1);
        chk("t1_data", m0_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        do_wr(0, 10'h155, 4'd1, 32'h11223344, 4'hF, 0, 0);
        do_wr(0, 10'h155, 4'd0, 32'h0000AB00, 4'b0010, 0, 0);
        do_rd(0, 10'h155, 4'd1);
        @(negedge clk);
        chk("t5_merge", m0_readdata, 32'h1122AB44);
        @(posedge clk); #1;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            a_r[m] = AW'($urandom); bc_r[m] = BW'(1); rd_r[m] = 1'b1;
        end
        reset_n = 1'b1;
        first_grant(w);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            exp_w = i % 2;
            w = {m1_waitrequest, m0_waitrequest};
            chk($sformatf("t2_grant%0d", i), 32'(w),
                exp_w == 0 ? 32'd2 : 32'd1);
            push(exp_w, shadow[idx(a_r[exp_w], 0)]);
            @(posedge clk); #1;
            a_r[exp_w] = AW'($urandom);
        end
        rd_r[0] = 1'b0; rd_r[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        a_r[1] = 10'h3FE; bc_r[1] = BW'(4); rd_r[1] = 1'b1;
        wait_accept(1, 1'b0, ok);
        chk("t3_addr0", 32'(mem_address), 32'h3FE);
        for (int k = 0; k < 4; k++) push(1, shadow[idx(10'h3FE, k)]);
        @(posedge clk); #1;
        rd_r[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ea = 10'h3FE + AW'(i);
            if (i < 4) chk($sformatf("t3_addr%0d", i),
                           32'({mem_chipselect, mem_address}),
                           32'({1'b1, ea}));
            chk($sformatf("t3_valid%0d", i), 32'(m1_readdatavalid), 32'd1);
        end
        @(negedge clk);
        chk("t3_valid_end", 32'(m1_readdatavalid), 32'd0);
        @(posedge clk); #1;

        m0_done = 1'b0;
        fork
            begin
                do_wr(0, AW'($urandom), BW'(4), $urandom, 4'hF, 2, 3);
                m0_done = 1'b1;
            end
            begin
                a_r[1] = AW'($urandom); bc_r[1] = BW'(1); rd_r[1] = 1'b1;
                writes = 0; first = -1; last = -1; bad = 0; cnt = 0;
                while (cnt < 200) begin
                    @(negedge clk);
                    if (m0_done) break;
                    if (!m1_waitrequest) bad++;
                    if (mem_chipselect && mem_write) begin
                        writes++;
                        if (first < 0) first = cnt;
                        last = cnt;
                    end
                    cnt++;
                end
                wait_accept(1, 1'b1, ok);
                if (ok) push(1, shadow[idx(a_r[1], 0)]);
                @(posedge clk); #1;
                rd_r[1] = 1'b0;
            end
        join
        chk("t4_writes", 32'(writes), 32'd4);
        chk("t4_stalls", 32'(last - first + 1 - writes), 32'd3);
        chk("t4_m1_held", 32'(bad), 32'd0);

        do_rd(0, AW'($urandom), BW'(8));
        @(posedge clk); #1;
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        #1;
        chk("t6_valid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        chk("t6_wait", 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
        chk("t6_cs", 32'(mem_chipselect), 32'd0);
        chk("t6_rdata", m0_readdata, 32'd0);
        for (int m = 0; m < 2; m++) begin
            a_r[m] = AW'($urandom); bc_r[m] = BW'(1); rd_r[m] = 1'b1;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        first_grant(w);
        chk("t6_first_m0", 32'(w), 32'd2);
        push(0, shadow[idx(a_r[0], 0)]);
        @(posedge clk); #1;
        rd_r[0] = 1'b0;
        wait_accept(1, 1'b0, ok);
        if (ok) push(1, shadow[idx(a_r[1], 0)]);
        @(posedge clk); #1;
        rd_r[1] = 1'b0;

        fork
            rand_ops(0);
            rand_ops(1);
        join
        repeat (12) @(posedge clk);
        #1;
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
